// File: rtl/fp_mult_pkg.sv
// ---------------------------------------------------------------------------
// fp_mult_pkg
// Shared types for the fp_mult datapath and its result checker:
//   - round_values          : rounding-mode encoding used by fp_mult_top
//   - ieee_single_precision : field view of a binary32 word
//   - ST_*                  : bit positions inside the 8-bit status word
//   - is_nan/is_inf/is_zero : classification of a binary32 word
//   - chk_state_t           : result-checker control states
// ---------------------------------------------------------------------------
package fp_mult_pkg;

    typedef enum logic [2:0] {
        RND_NEAR_EVEN   = 3'd0,
        RND_TO_ZERO     = 3'd1,
        RND_POS_INF     = 3'd2,
        RND_NEG_INF     = 3'd3,
        RND_NEAR_MAXMAG = 3'd4
    } round_values;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } ieee_single_precision;

    // status = {div_by_0, unused, inexact, huge, tiny, nan, inf, zero}
    localparam int ST_ZERO    = 0;
    localparam int ST_INF     = 1;
    localparam int ST_NAN     = 2;
    localparam int ST_TINY    = 3;
    localparam int ST_HUGE    = 4;
    localparam int ST_INEXACT = 5;
    localparam int ST_UNUSED  = 6;
    localparam int ST_DIV0    = 7;

    typedef enum logic [1:0] {
        CHK_IDLE = 2'd0,
        CHK_RUN  = 2'd1,
        CHK_HALT = 2'd2
    } chk_state_t;

    function automatic logic is_nan(input logic [31:0] v);
        ieee_single_precision f;
        f = v;
        return (f.exponent == 8'hFF) && (f.mantissa != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] v);
        ieee_single_precision f;
        f = v;
        return (f.exponent == 8'hFF) && (f.mantissa == 23'd0);
    endfunction

    // Both +0 and -0 count as zero; the sign bit is ignored.
    function automatic logic is_zero(input logic [31:0] v);
        return v[30:0] == 31'd0;
    endfunction

endpackage

// File: rtl/fp_mult_result_checker_delay_line.sv
// ---------------------------------------------------------------------------
// fp_op_delay_line
// Fixed-depth shift register aligning {valid, a, b} with the multiplier's
// results. Shifts every cycle; reset clears only the valid bit (MSB) of each
// stage, the operand payload is left as-is.
// Ports:
//   clk    in  1      clock
//   rst    in  1      synchronous active-high reset (valid bits only)
//   i_data in  WIDTH  {valid, a, b} entering the pipe
//   o_data out WIDTH  {valid, a, b} delayed by DEPTH cycles
// ---------------------------------------------------------------------------
module fp_op_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
        r_stage[0] <= i_data;
        for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
        end
        // Later assignment wins: valid bits are forced low, payload keeps shifting.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i][WIDTH-1] <= 1'b0;
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/fp_mult_result_checker.sv
// ---------------------------------------------------------------------------
// fp_mult_result_checker
// End-of-pipe monitor for fp_mult_top. Realigns operands a/b to the result
// cycle, checks z against z_ref and the status word against z, counts
// passes/errors and latches the first failing record.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, clear    control pulses (clear dominates start)
//   in_valid, a, b  operands as they enter fp_mult_top
//   z, z_ref        DUT result and golden result
//   status          {div_by_0,unused,inexact,huge,tiny,nan,inf,zero}
//   busy, halted    state decode (RUN / HALT)
//   err_flag        sticky error indicator
//   pass_count      saturating count of passing checks
//   err_count       saturating count of failing checks
//   first_err_*     operands, result, reference, status and kind of the
//                   first failure (kind bit0 value, bit1 status)
// ---------------------------------------------------------------------------
module fp_mult_result_checker
    import fp_mult_pkg::*;
#(
    parameter int LATENCY     = 2,
    parameter int STOP_ON_ERR = 1,
    parameter int NAN_LOOSE   = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic [31:0]      z,
    input  logic [31:0]      z_ref,
    input  logic [7:0]       status,
    output logic             busy,
    output logic             halted,
    output logic             err_flag,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] err_count,
    output logic [31:0]      first_err_a,
    output logic [31:0]      first_err_b,
    output logic [31:0]      first_err_z,
    output logic [31:0]      first_err_zref,
    output logic [7:0]       first_err_stat,
    output logic [1:0]       first_err_kind
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [64:0] w_tail;
    logic        w_rvalid;
    logic [31:0] w_ra;
    logic [31:0] w_rb;

    fp_op_delay_line #(
        .DEPTH (LATENCY),
        .WIDTH (65)
    ) u_delay (
        .clk    (clk),
        .rst    (rst),
        .i_data ({in_valid, a, b}),
        .o_data (w_tail)
    );

    assign w_rvalid = w_tail[64];
    assign w_ra     = w_tail[63:32];
    assign w_rb     = w_tail[31:0];

    chk_state_t       r_state;
    logic             r_err_flag;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [31:0]      r_fa, r_fb, r_fz, r_fr;
    logic [7:0]       r_fs;
    logic [1:0]       r_fk;

    logic       w_check;
    logic       w_val_match;
    logic       w_stat_ok;
    logic [1:0] w_kind;
    logic       w_fail;

    assign w_check     = (r_state == CHK_RUN) && w_rvalid;
    // Loose NaN compare: any NaN matches any NaN regardless of sign/payload.
    assign w_val_match = (z == z_ref) ||
                         ((NAN_LOOSE != 0) && is_nan(z) && is_nan(z_ref));
    assign w_stat_ok   = (status[ST_DIV0:ST_UNUSED] == 2'b00) &&
                         (status[ST_NAN]  == is_nan(z))  &&
                         (status[ST_INF]  == is_inf(z))  &&
                         (status[ST_ZERO] == is_zero(z)) &&
                         (!status[ST_HUGE] || status[ST_INEXACT]);
    assign w_kind      = {~w_stat_ok, ~w_val_match};
    assign w_fail      = |w_kind;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state    <= CHK_IDLE;
            r_err_flag <= 1'b0;
            r_pass_cnt <= '0;
            r_err_cnt  <= '0;
            r_fa       <= '0;
            r_fb       <= '0;
            r_fz       <= '0;
            r_fr       <= '0;
            r_fs       <= '0;
            r_fk       <= '0;
        end else begin
            if (w_check) begin
                if (w_fail) begin
                    r_err_cnt  <= sat_inc(r_err_cnt);
                    r_err_flag <= 1'b1;
                    if (r_err_cnt == '0) begin
                        r_fa <= w_ra;
                        r_fb <= w_rb;
                        r_fz <= z;
                        r_fr <= z_ref;
                        r_fs <= status;
                        r_fk <= w_kind;
                    end
                end else begin
                    r_pass_cnt <= sat_inc(r_pass_cnt);
                end
            end

            case (r_state)
                CHK_IDLE: if (start) r_state <= CHK_RUN;
                CHK_RUN:  if (w_check && w_fail && (STOP_ON_ERR != 0)) r_state <= CHK_HALT;
                CHK_HALT: if (start) r_state <= CHK_RUN;
                default:  r_state <= CHK_IDLE;
            endcase
        end
    end

    assign busy           = (r_state == CHK_RUN);
    assign halted         = (r_state == CHK_HALT);
    assign err_flag       = r_err_flag;
    assign pass_count     = r_pass_cnt;
    assign err_count      = r_err_cnt;
    assign first_err_a    = r_fa;
    assign first_err_b    = r_fb;
    assign first_err_z    = r_fz;
    assign first_err_zref = r_fr;
    assign first_err_stat = r_fs;
    assign first_err_kind = r_fk;

endmodule

// File: tb/tb_fp_mult_result_checker.sv
module tb_fp_mult_result_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, clear, in_valid;
    logic [31:0] a, b, z, z_ref;
    logic [7:0]  status;

    // Instance A: LATENCY=2, halt on error, loose NaN, 32-bit counters
    logic        a_busy, a_halted, a_eflag;
    logic [31:0] a_pc, a_ec, a_fa, a_fb, a_fz, a_fr;
    logic [7:0]  a_fs;
    logic [1:0]  a_fk;
    // Instance B: LATENCY=3, keep counting, exact NaN, 3-bit counters
    logic        b_busy, b_halted, b_eflag;
    logic [2:0]  b_pc, b_ec;
    logic [31:0] b_fa, b_fb, b_fz, b_fr;
    logic [7:0]  b_fs;
    logic [1:0]  b_fk;

    fp_mult_result_checker #(.LATENCY(2), .STOP_ON_ERR(1), .NAN_LOOSE(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .in_valid(in_valid),
        .a(a), .b(b), .z(z), .z_ref(z_ref), .status(status),
        .busy(a_busy), .halted(a_halted), .err_flag(a_eflag),
        .pass_count(a_pc), .err_count(a_ec),
        .first_err_a(a_fa), .first_err_b(a_fb), .first_err_z(a_fz),
        .first_err_zref(a_fr), .first_err_stat(a_fs), .first_err_kind(a_fk));

    fp_mult_result_checker #(.LATENCY(3), .STOP_ON_ERR(0), .NAN_LOOSE(0), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .in_valid(in_valid),
        .a(a), .b(b), .z(z), .z_ref(z_ref), .status(status),
        .busy(b_busy), .halted(b_halted), .err_flag(b_eflag),
        .pass_count(b_pc), .err_count(b_ec),
        .first_err_a(b_fa), .first_err_b(b_fb), .first_err_z(b_fz),
        .first_err_zref(b_fr), .first_err_stat(b_fs), .first_err_kind(b_fk));

    // ---------------- reference model ----------------
    // st: 0 idle, 1 run, 2 halt
    typedef struct {
        int          st;
        longint      pc;
        longint      ec;
        bit          flag;
        logic [31:0] fa, fb, fz, fr;
        logic [7:0]  fs;
        logic [1:0]  fk;
    } mrec_t;

    localparam int MAXC = 8192;

    mrec_t  m [2];
    mrec_t  qa [$];
    mrec_t  qb [$];
    int     lat  [2] = '{2, 3};
    bit     stop [2] = '{1'b1, 1'b0};
    bit     nanl [2] = '{1'b1, 1'b0};
    longint cmax [2] = '{64'hFFFF_FFFF, 7};

    bit          hv [MAXC];
    logic [31:0] ha [MAXC];
    logic [31:0] hb [MAXC];
    logic [31:0] pz [MAXC];
    logic [31:0] pr [MAXC];
    logic [7:0]  ps [MAXC];
    int cyc = 0;
    int last_rst = -1;

    int errors = 0;
    int checks = 0;

    function automatic bit f_nan(logic [31:0] v);
        return ((v >> 23) & 32'hFF) == 32'hFF && (v & 32'h7F_FFFF) != 0;
    endfunction
    function automatic bit f_inf(logic [31:0] v);
        return ((v >> 23) & 32'hFF) == 32'hFF && (v & 32'h7F_FFFF) == 0;
    endfunction
    function automatic bit f_zero(logic [31:0] v);
        return (v & 32'h7FFF_FFFF) == 0;
    endfunction

    function automatic mrec_t mclear();
        mrec_t r;
        r.st = 0; r.pc = 0; r.ec = 0; r.flag = 0;
        r.fa = 0; r.fb = 0; r.fz = 0; r.fr = 0; r.fs = 0; r.fk = 0;
        return r;
    endfunction

    function automatic void model_step(int d);
        int src, old;
        bit rv, chk, vm, sok, fail;
        if (rst || clear) begin
            m[d] = mclear();
            return;
        end
        src = cyc - lat[d];
        rv  = (src >= 0) && (src > last_rst) && hv[src];
        old = m[d].st;
        chk = (old == 1) && rv;
        fail = 0;
        if (chk) begin
            vm  = (z == z_ref) || (nanl[d] && f_nan(z) && f_nan(z_ref));
            sok = (status / 64 == 0) &&
                  (status[2] == f_nan(z)) && (status[1] == f_inf(z)) &&
                  (status[0] == f_zero(z)) && (!status[4] || status[5]);
            fail = !vm || !sok;
            if (fail) begin
                if (m[d].ec == 0) begin
                    m[d].fa = ha[src]; m[d].fb = hb[src];
                    m[d].fz = z; m[d].fr = z_ref; m[d].fs = status;
                    m[d].fk = {!sok, !vm};
                end
                if (m[d].ec < cmax[d]) m[d].ec++;
                m[d].flag = 1;
            end else begin
                if (m[d].pc < cmax[d]) m[d].pc++;
            end
        end
        if (old == 1 && fail && stop[d]) m[d].st = 2;
        else if (old != 1 && start)      m[d].st = 1;
    endfunction

    // ---------------- stimulus ----------------
    task automatic tick(bit s, bit c, bit r, bit v, logic [31:0] ia, logic [31:0] ib,
                        logic [31:0] iz, logic [31:0] izr, logic [7:0] ist);
        @(negedge clk);
        start = s; clear = c; rst = r; in_valid = v;
        a = ia; b = ib; z = iz; z_ref = izr; status = ist;
        hv[cyc] = v; ha[cyc] = ia; hb[cyc] = ib;
        model_step(0);
        model_step(1);
        if (r) last_rst = cyc;
        qa.push_back(m[0]);
        qb.push_back(m[1]);
        cyc++;
    endtask

    task automatic idle(bit s, bit c, bit r);
        tick(s, c, r, 1'b0, 32'h0, 32'h0, pz[cyc], pr[cyc], ps[cyc]);
    endtask

    // Issue one operand pair; its result is presented at both +2 and +3 so each
    // instance sees it at its own latency. Followed by 3 quiet cycles.
    task automatic issue(logic [31:0] ia, logic [31:0] ib, logic [31:0] iz,
                         logic [31:0] izr, logic [7:0] ist);
        pz[cyc+2] = iz; pr[cyc+2] = izr; ps[cyc+2] = ist;
        pz[cyc+3] = iz; pr[cyc+3] = izr; ps[cyc+3] = ist;
        tick(1'b0, 1'b0, 1'b0, 1'b1, ia, ib, pz[cyc], pr[cyc], ps[cyc]);
        repeat (3) idle(1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 8))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h3F80_0000;
            3: return 32'h7F80_0000;
            4: return 32'hFF80_0000;
            5: return 32'h7FC0_0000;
            6: return 32'hFFC0_0001;
            7: return 32'h7F80_0001;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [7:0] good_status(logic [31:0] v);
        logic [7:0] s;
        s = 8'h00;
        if (f_zero(v)) s = s | 8'h01;
        if (f_inf(v))  s = s | 8'h02;
        if (f_nan(v))  s = s | 8'h04;
        if ($urandom_range(0, 3) == 0) s = s | 8'h08;
        if ($urandom_range(0, 1) == 0) begin
            s = s | 8'h20;
            if ($urandom_range(0, 1) == 0) s = s | 8'h10;
        end
        return s;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d: got %0h expected %0h", n, cyc, act, exp);
        end
    endtask

    initial begin
        mrec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("A.busy",    64'(a_busy),   64'(e.st == 1));
                chk("A.halted",  64'(a_halted), 64'(e.st == 2));
                chk("A.err_flag",64'(a_eflag),  64'(e.flag));
                chk("A.pass_cnt",64'(a_pc),     64'(e.pc));
                chk("A.err_cnt", 64'(a_ec),     64'(e.ec));
                chk("A.first_ab",{a_fa, a_fb},  {e.fa, e.fb});
                chk("A.first_zr",{a_fz, a_fr},  {e.fz, e.fr});
                chk("A.first_sk",64'({a_fs, a_fk}), 64'({e.fs, e.fk}));
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("B.busy",    64'(b_busy),   64'(e.st == 1));
                chk("B.halted",  64'(b_halted), 64'(e.st == 2));
                chk("B.err_flag",64'(b_eflag),  64'(e.flag));
                chk("B.pass_cnt",64'(b_pc),     64'(e.pc));
                chk("B.err_cnt", 64'(b_ec),     64'(e.ec));
                chk("B.first_ab",{b_fa, b_fb},  {e.fa, e.fb});
                chk("B.first_zr",{b_fz, b_fr},  {e.fz, e.fr});
                chk("B.first_sk",64'({b_fs, b_fk}), 64'({e.fs, e.fk}));
            end
        end
    end

    initial begin
        logic [31:0] rz, rzr;
        logic [7:0]  rs;
        rst = 1'b1; start = 1'b0; clear = 1'b0; in_valid = 1'b0;
        a = 0; b = 0; z = 0; z_ref = 0; status = 0;
        m[0] = mclear();
        m[1] = mclear();
        // default presented result: +0 with correct zero status -> passes
        for (int i = 0; i < MAXC; i++) begin
            pz[i] = 32'h0; pr[i] = 32'h0; ps[i] = 8'h01;
        end

        repeat (3) idle(1'b0, 1'b0, 1'b1);
        idle(1'b1, 1'b0, 1'b0);
        issue(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 8'h00);
        issue(32'h1234_5678, 32'h9ABC_DEF0, 32'h3F80_0001, 32'h3F80_0000, 8'h00);
        idle(1'b1, 1'b0, 1'b0);
        issue(32'h0000_0001, 32'h0000_0002, 32'h7FC0_0000, 32'hFF80_0001, 8'h04);
        idle(1'b1, 1'b0, 1'b0);
        issue(32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 8'h00);
        idle(1'b1, 1'b0, 1'b0);
        issue(32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 32'h0000_0000, 8'h01);
        // huge without inexact, and reserved bits set
        issue(32'h0000_0007, 32'h0000_0008, 32'h3F80_0000, 32'h3F80_0000, 8'h10);
        issue(32'h0000_0009, 32'h0000_000A, 32'h3F80_0000, 32'h3F80_0000, 8'h40);
        // clear and start together: clear wins, then results arrive while idle
        idle(1'b1, 1'b1, 1'b0);
        issue(32'h0000_000B, 32'h0000_000C, 32'h3F80_0001, 32'h3F80_0000, 8'h00);
        idle(1'b1, 1'b0, 1'b0);
        // enough passes to saturate the 3-bit counters of instance B
        for (int i = 0; i < 10; i++)
            issue($urandom, $urandom, 32'h4000_0000, 32'h4000_0000, 8'h20);
        // reset while operands are in flight
        tick(1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA_0001, 32'hBBBB_0001, 32'h0, 32'h0, 8'h01);
        idle(1'b0, 1'b0, 1'b1);
        idle(1'b1, 1'b0, 1'b0);
        repeat (4) idle(1'b0, 1'b0, 1'b0);

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            rzr = rand_val();
            rz  = ($urandom_range(0, 5) == 0) ? rand_val() : rzr;
            rs  = good_status(rz);
            if ($urandom_range(0, 7) == 0) rs = rs ^ (8'h01 << $urandom_range(0, 7));
            tick($urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 249) == 0, $urandom_range(0, 3) != 0,
                 $urandom, $urandom, rz, rzr, rs);
        end

        idle(1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d expected records left unchecked", qa.size(), qb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
